// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset/exception vectors and state encoding for the IF stage.
package fetch_unit_pkg;

  localparam int          FU_VADDR_W     = 32;
  localparam int          FU_INSTR_W     = 32;
  localparam logic [31:0] FU_NOP         = 32'h0000_0000;
  localparam logic [31:0] FU_BOOT_PC     = 32'h0000_1000;
  localparam logic [31:0] FU_EXC_VECTOR  = 32'h0000_2000;

  // FETCH     : lookup PC in the iTLB, issue the I-cache request on a hit
  // WAIT_MEM  : request outstanding, response will be delivered or held
  // DRAIN     : request outstanding but redirected away, response discarded
  // ITLB_MISS : refill in flight, nothing reaches the bank
  // HOLD      : response captured while ID stalled, waiting to hand it over
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_WAIT_MEM  = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_ITLB_MISS = 3'd3,
    ST_HOLD      = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset vector, redirect target, or sequential +4 (wraps).
module fetch_pc_reg #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect_i,
  input  logic [AW-1:0] target_i,
  input  logic          advance_i,
  output logic [AW-1:0] pc_o
);

  logic [AW-1:0] pc_q, pc_d;

  // redirect beats sequential advance; the add is modulo 2^AW by width
  always_comb begin
    pc_d = pc_q;
    if (redirect_i)     pc_d = target_i;
    else if (advance_i) pc_d = pc_q + AW'(4);
  end

  // PC register, synchronous active-low reset to the boot vector
  always_ff @(posedge clk) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, looks it up in the iTLB, fetches from the I-cache
// and feeds the IF/ID bank, handling refills, redirects and ID stalls.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                          VIRTUAL_ADDR_WIDTH = FU_VADDR_W,
  parameter int                          INSTRUCTION_WIDTH  = FU_INSTR_W,
  parameter logic [VIRTUAL_ADDR_WIDTH-1:0] BOOT_PC    = VIRTUAL_ADDR_WIDTH'(FU_BOOT_PC),
  parameter logic [VIRTUAL_ADDR_WIDTH-1:0] EXC_VECTOR = VIRTUAL_ADDR_WIDTH'(FU_EXC_VECTOR)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall_ID,
  input  logic                          branch_taken,
  input  logic [VIRTUAL_ADDR_WIDTH-1:0] branch_target,
  input  logic                          exception,
  input  logic                          itlb_hit,
  output logic                          itlb_refill_req,
  input  logic                          itlb_refill_done,
  output logic [VIRTUAL_ADDR_WIDTH-1:0] itlb_addr,
  output logic                          icache_req,
  output logic [VIRTUAL_ADDR_WIDTH-1:0] icache_addr,
  input  logic                          icache_valid,
  input  logic [INSTRUCTION_WIDTH-1:0]  icache_data,
  output logic [INSTRUCTION_WIDTH-1:0]  instruction_IF,
  output logic [VIRTUAL_ADDR_WIDTH-1:0] PC_IF,
  output logic                          iTLB_hit_IF,
  output logic                          load_IF_ID,
  output logic                          flush_IF_ID
);

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(FU_NOP);

  fetch_state_e                   state_q, state_d;
  logic [INSTRUCTION_WIDTH-1:0]   hold_q, hold_d;
  logic [VIRTUAL_ADDR_WIDTH-1:0]  pc;
  logic [VIRTUAL_ADDR_WIDTH-1:0]  redir_raw, redir_target;
  logic                           redirect, advance;

  // exception outranks a branch; targets are forced word aligned
  assign redirect     = exception | branch_taken;
  assign redir_raw    = exception ? EXC_VECTOR : branch_target;
  assign redir_target = {redir_raw[VIRTUAL_ADDR_WIDTH-1:2], 2'b00};

  fetch_pc_reg #(
    .AW       (VIRTUAL_ADDR_WIDTH),
    .RESET_PC (BOOT_PC)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .redirect_i (redirect),
    .target_i   (redir_target),
    .advance_i  (advance),
    .pc_o       (pc)
  );

  // lookup and request always carry the current PC
  assign itlb_addr   = pc;
  assign icache_addr = pc;

  // next-state, hold-buffer capture and bank-facing output muxing
  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    advance         = 1'b0;
    icache_req      = 1'b0;
    itlb_refill_req = 1'b0;
    instruction_IF  = NOP;
    iTLB_hit_IF     = 1'b0;
    PC_IF           = pc;
    load_IF_ID      = !stall_ID;
    flush_IF_ID     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (itlb_hit) begin
          // a request fired alongside a redirect is for the old PC; drain it
          icache_req = 1'b1;
          state_d    = redirect ? ST_DRAIN : ST_WAIT_MEM;
        end else if (!redirect) begin
          state_d = ST_ITLB_MISS;
        end
      end
      ST_WAIT_MEM: begin
        if (redirect) begin
          // a response landing in the redirect cycle is dropped right here
          state_d = icache_valid ? ST_FETCH : ST_DRAIN;
        end else if (icache_valid) begin
          if (!stall_ID) begin
            instruction_IF = icache_data;
            iTLB_hit_IF    = 1'b1;
            load_IF_ID     = 1'b1;
            advance        = 1'b1;
            state_d        = ST_FETCH;
          end else begin
            hold_d  = icache_data;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_FETCH;
        end else begin
          instruction_IF = hold_q;
          iTLB_hit_IF    = 1'b1;
          if (!stall_ID) begin
            advance = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (icache_valid) state_d = ST_FETCH;
      end
      ST_ITLB_MISS: begin
        // a redirect here only moves the PC; the refill still completes
        itlb_refill_req = 1'b1;
        if (itlb_refill_done) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    if (redirect) begin
      flush_IF_ID = 1'b1;
      load_IF_ID  = 1'b0;
    end

    // while reset is low the bank is flushed and the cache/TLB left alone
    if (!reset) begin
      flush_IF_ID     = 1'b1;
      load_IF_ID      = 1'b0;
      icache_req      = 1'b0;
      itlb_refill_req = 1'b0;
      instruction_IF  = NOP;
      iTLB_hit_IF     = 1'b0;
      PC_IF           = BOOT_PC;
    end
  end

  // state and hold buffer; reset abandons any outstanding transaction
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      hold_q  <= NOP;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // the bank is never loaded and flushed together
  a_no_load_flush: assert property (@(posedge clk) !(flush_IF_ID && load_IF_ID));
  // requests only ever go out for a translated PC
  a_req_hit: assert property (@(posedge clk) disable iff (!reset) icache_req |-> itlb_hit);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, every cycle
// compared against a flag-based model of the fetch pipeline.
module tb_fetch_unit;

  localparam logic [31:0] BOOT = 32'h0000_1000;
  localparam logic [31:0] EXCV = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset, stall_ID, branch_taken, exception, itlb_hit;
  logic [31:0] branch_target;
  logic        itlb_refill_req, itlb_refill_done;
  logic [31:0] itlb_addr;
  logic        icache_req, icache_valid;
  logic [31:0] icache_addr, icache_data;
  logic [31:0] instruction_IF, PC_IF;
  logic        iTLB_hit_IF, load_IF_ID, flush_IF_ID;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall_ID(stall_ID), .branch_taken(branch_taken),
    .branch_target(branch_target), .exception(exception), .itlb_hit(itlb_hit),
    .itlb_refill_req(itlb_refill_req), .itlb_refill_done(itlb_refill_done),
    .itlb_addr(itlb_addr), .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_data(icache_data),
    .instruction_IF(instruction_IF), .PC_IF(PC_IF), .iTLB_hit_IF(iTLB_hit_IF),
    .load_IF_ID(load_IF_ID), .flush_IF_ID(flush_IF_ID)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // instruction memory contents as a pure function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // responders: I-cache with programmable latency, iTLB refill engine
  int lat_lo = 1, lat_hi = 1, ref_lo = 4, ref_hi = 4;
  int pend = 0, rcnt = 0;
  bit rbusy = 0;
  logic [31:0] pend_addr;

  // model: PC plus which kind of work is pending
  logic [31:0] m_pc;
  bit m_wait, m_drain, m_held, m_miss;

  // logs for the directed checks
  logic [31:0] dlv_q[$];
  logic [31:0] req_q[$];
  int ref_cycles = 0;

  task automatic model_check();
    logic [31:0] e_ins, e_pc, n_pc, tgt;
    logic e_hit, e_load, e_flush, e_req, e_ref, redir;
    if (!reset) begin
      e_ins = 0; e_hit = 0; e_pc = BOOT; e_load = 0; e_flush = 1; e_req = 0; e_ref = 0;
      m_pc = BOOT; m_wait = 0; m_drain = 0; m_held = 0; m_miss = 0;
      n_pc = BOOT;
    end else begin
      redir = exception | branch_taken;
      tgt   = exception ? EXCV : branch_target;
      tgt[1:0] = 2'b00;
      n_pc = m_pc; e_pc = m_pc; e_ins = 0; e_hit = 0;
      e_load = !stall_ID; e_flush = 0; e_req = 0; e_ref = 0;
      if (m_miss) begin
        e_ref = 1;
        if (itlb_refill_done) m_miss = 0;
      end else if (m_held) begin
        if (redir) m_held = 0;
        else begin
          e_ins = mem_word(m_pc); e_hit = 1;
          if (!stall_ID) begin n_pc = m_pc + 4; m_held = 0; end
        end
      end else if (m_wait) begin
        if (redir) begin m_wait = 0; m_drain = !icache_valid; end
        else if (icache_valid) begin
          m_wait = 0;
          if (!stall_ID) begin e_ins = mem_word(m_pc); e_hit = 1; n_pc = m_pc + 4; end
          else m_held = 1;
        end
      end else if (m_drain) begin
        if (icache_valid) m_drain = 0;
      end else begin
        if (itlb_hit) begin
          e_req = 1;
          if (redir) m_drain = 1; else m_wait = 1;
        end else if (!redir) m_miss = 1;
      end
      if (redir) begin e_flush = 1; e_load = 0; n_pc = tgt; end
      chk("itlb_addr", itlb_addr, m_pc);
    end
    chk("flush", flush_IF_ID, e_flush);
    chk("load", load_IF_ID, e_load);
    chk("icache_req", icache_req, e_req);
    chk("refill_req", itlb_refill_req, e_ref);
    chk("instr", instruction_IF, e_ins);
    chk("pc_if", PC_IF, e_pc);
    chk("hit_if", iTLB_hit_IF, e_hit);
    if (e_req) chk("icache_addr", icache_addr, m_pc);
    m_pc = n_pc;
  endtask

  task automatic cyc(input logic rst, input logic hit, input logic stl,
                     input logic br, input logic exc, input logic [31:0] tgt);
    @(posedge clk); #1;
    icache_valid = 1'b0;
    icache_data  = $urandom;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin icache_valid = 1'b1; icache_data = mem_word(pend_addr); end
    end
    itlb_refill_done = 1'b0;
    if (rbusy) begin
      rcnt--;
      if (rcnt == 0) begin itlb_refill_done = 1'b1; rbusy = 0; end
    end
    reset = rst; itlb_hit = hit; stall_ID = stl;
    branch_taken = br; exception = exc; branch_target = tgt;
    @(negedge clk);
    model_check();
    if (load_IF_ID && iTLB_hit_IF) dlv_q.push_back(PC_IF);
    if (icache_req) begin
      req_q.push_back(icache_addr);
      pend = lat_lo + int'($urandom % (lat_hi - lat_lo + 1));
      pend_addr = icache_addr;
    end
    if (itlb_refill_req) ref_cycles++;
    if (itlb_refill_req && !rbusy && !itlb_refill_done) begin
      rbusy = 1;
      rcnt = ref_lo + int'($urandom % (ref_hi - ref_lo + 1));
    end
  endtask

  function automatic int count_in(input logic [31:0] q[$], input logic [31:0] v);
    int n = 0;
    foreach (q[i]) if (q[i] == v) n++;
    return n;
  endfunction

  initial begin
    reset = 1'b0; stall_ID = 1'b0; branch_taken = 1'b0; exception = 1'b0;
    itlb_hit = 1'b1; branch_target = '0; itlb_refill_done = 1'b0;
    icache_valid = 1'b0; icache_data = '0;

    // reset held three cycles
    repeat (3) cyc(0, 1, 0, 0, 0, 0);

    // straight-line fetch, one-cycle responses
    dlv_q.delete(); req_q.delete();
    repeat (6) cyc(1, 1, 0, 0, 0, 0);
    chk("first_req", req_q[0], 32'h1000);
    chk("dlv_cnt", dlv_q.size(), 3);
    chk("dlv0", dlv_q[0], 32'h1000);
    chk("dlv1", dlv_q[1], 32'h1004);
    chk("dlv2", dlv_q[2], 32'h1008);

    // stall across the response for 0x100C, released after three cycles
    cyc(1, 1, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("held_once", count_in(dlv_q, 32'h100C), 1);

    // exception to 0x2000 while idle on a miss, then a 5-cycle refill
    cyc(1, 0, 0, 0, 1, 0);
    ref_cycles = 0;
    repeat (6) cyc(1, 0, 0, 0, 0, 0);
    chk("refill_cycles", ref_cycles, 5);

    // reissue 0x2000, branch to 0x3002 while it is outstanding
    lat_lo = 3; lat_hi = 3;
    cyc(1, 1, 0, 0, 0, 0);
    chk("reissue", req_q[$], 32'h2000);
    cyc(1, 1, 0, 1, 0, 32'h3002);
    repeat (2) cyc(1, 1, 0, 0, 0, 0);
    lat_lo = 1; lat_hi = 1;
    cyc(1, 1, 0, 0, 0, 0);
    chk("br_req", req_q[$], 32'h3000);
    chk("stale_drop", count_in(dlv_q, 32'h2000), 0);
    cyc(1, 1, 0, 0, 0, 0);

    // exception + branch + stall in one cycle
    cyc(1, 1, 1, 1, 1, 32'h5555_5554);
    chk("exc_flush", flush_IF_ID, 1);
    chk("exc_load", load_IF_ID, 0);
    repeat (2) cyc(1, 1, 0, 0, 0, 0);
    chk("exc_req", req_q[$], EXCV);

    // wrap from the top of the address space
    cyc(1, 0, 0, 1, 0, 32'hFFFF_FFFC);
    repeat (4) cyc(1, 1, 0, 0, 0, 0);
    chk("wrap_prev", req_q[$-1], 32'hFFFF_FFFC);
    chk("wrap_req", req_q[$], 32'h0000_0000);

    // random traffic
    lat_lo = 1; lat_hi = 3; ref_lo = 1; ref_hi = 5;
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 60) != 0, ($urandom % 4) != 0, ($urandom % 10) < 3,
          ($urandom % 12) == 0, ($urandom % 30) == 0, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
